// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - vend request / coin hopper signal bundle for change_dispenser
// Signals:
//   vend_req, credit     vend request and credit in cents from the vending FSM
//   hopper_ack           hopper confirms the strobed coin was ejected
//   busy, item_rel       activity flag and item release solenoid drive
//   coin50/coin10/coin5  coin eject strobes (at most one high)
//   change_due           change still owed, in cents
//   done, err, jam       vend complete pulse, underpay pulse, sticky hopper fault
// master: requester and hopper side; slave: change_dispenser.
interface change_dispenser_if #(
  parameter int CW = 8
);
  logic          vend_req;
  logic [CW-1:0] credit;
  logic          hopper_ack;
  logic          busy;
  logic          item_rel;
  logic          coin50;
  logic          coin10;
  logic          coin5;
  logic [CW-1:0] change_due;
  logic          done;
  logic          err;
  logic          jam;

  modport master (
    output vend_req, credit, hopper_ack,
    input  busy, item_rel, coin50, coin10, coin5, change_due, done, err, jam
  );

  modport slave (
    input  vend_req, credit, hopper_ack,
    output busy, item_rel, coin50, coin10, coin5, change_due, done, err, jam
  );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - item release pulse then greedy 50c/10c/5c change payout with hopper jam detection
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset
//   bus  change_dispenser_if slave: vend_req/credit/hopper_ack in;
//        busy/item_rel/coin50/coin10/coin5/change_due/done/err/jam out
module change_dispenser #(
  parameter int PRICE       = 125,
  parameter int CW          = 8,
  parameter int REL_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic               CLK,
  input  logic               RST,
  change_dispenser_if.slave  bus
);

  // One counter serves both the release pulse and the ack timeout.
  localparam int CNT_MAX = (ACK_TIMEOUT > REL_CYCLES) ? ACK_TIMEOUT : REL_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   LP_PRICE    = CW'(PRICE);
  localparam logic [CNTW-1:0] LP_REL_LAST = CNTW'(REL_CYCLES - 1);
  localparam logic [CNTW-1:0] LP_ACK_LAST = CNTW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_SELECT,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_50,
    C_10,
    C_5
  } coin_t;

  state_t          r_state, w_state_nxt;
  coin_t           r_coin, w_coin_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0]   r_change, w_change_nxt;
  logic            r_err, w_err_nxt;
  logic            r_jam, w_jam_nxt;
  logic [CW-1:0]   w_coin_val;

  always_comb begin
    w_coin_val = '0;
    unique case (r_coin)
      C_50:    w_coin_val = CW'(50);
      C_10:    w_coin_val = CW'(10);
      C_5:     w_coin_val = CW'(5);
      default: w_coin_val = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_coin   <= C_NONE;
      r_cnt    <= '0;
      r_change <= '0;
      r_err    <= 1'b0;
      r_jam    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_coin   <= w_coin_nxt;
      r_cnt    <= w_cnt_nxt;
      r_change <= w_change_nxt;
      r_err    <= w_err_nxt;
      r_jam    <= w_jam_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_coin_nxt   = r_coin;
    w_cnt_nxt    = r_cnt;
    w_change_nxt = r_change;
    w_err_nxt    = 1'b0;
    w_jam_nxt    = r_jam;
    unique case (r_state)
      S_IDLE: begin
        if (bus.vend_req) begin
          if (bus.credit >= LP_PRICE) begin
            w_change_nxt = bus.credit - LP_PRICE;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_RELEASE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (r_cnt == LP_REL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SELECT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SELECT: begin
        // Greedy choice: largest coin not exceeding the remaining change.
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_ACK;
        if (r_change >= CW'(50)) begin
          w_coin_nxt = C_50;
        end else if (r_change >= CW'(10)) begin
          w_coin_nxt = C_10;
        end else if (r_change >= CW'(5)) begin
          w_coin_nxt = C_5;
        end else begin
          w_coin_nxt  = C_NONE;
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT_ACK: begin
        // Ack wins over timeout when both land on the same edge.
        if (bus.hopper_ack) begin
          w_change_nxt = r_change - w_coin_val;
          w_cnt_nxt    = '0;
          w_coin_nxt   = C_NONE;
          w_state_nxt  = S_SELECT;
        end else if (r_cnt == LP_ACK_LAST) begin
          w_coin_nxt  = C_NONE;
          w_jam_nxt   = 1'b1;
          w_state_nxt = S_FAULT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.item_rel   = (r_state == S_RELEASE);
  assign bus.coin50     = (r_state == S_WAIT_ACK) && (r_coin == C_50);
  assign bus.coin10     = (r_state == S_WAIT_ACK) && (r_coin == C_10);
  assign bus.coin5      = (r_state == S_WAIT_ACK) && (r_coin == C_5);
  assign bus.change_due = r_change;
  assign bus.done       = (r_state == S_DONE);
  assign bus.err        = r_err;
  assign bus.jam        = r_jam;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
module tb_change_dispenser;
  localparam int PRICE = 125;
  localparam int CW    = 8;
  localparam int REL   = 4;
  localparam int TMO   = 16;

  localparam int P_IDLE  = 0;
  localparam int P_REL   = 1;
  localparam int P_SEL   = 2;
  localparam int P_STB   = 3;
  localparam int P_DONE  = 4;
  localparam int P_FAULT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  change_dispenser_if #(.CW(CW)) bus ();

  change_dispenser #(
    .PRICE(PRICE), .CW(CW), .REL_CYCLES(REL), .ACK_TIMEOUT(TMO)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: change is planned as a list of coins by division,
  // then consumed one coin at a time as the hopper acknowledges.
  int ph       = P_IDLE;
  int rel_left = 0;
  int waited   = 0;
  int cur      = 0;
  int m_due    = 0;
  bit m_err    = 1'b0;
  bit m_jam    = 1'b0;
  int coins[$];

  function automatic void plan(input int due);
    coins.delete();
    repeat (due / 50) coins.push_back(50);
    repeat ((due % 50) / 10) coins.push_back(10);
    repeat ((due % 10) / 5) coins.push_back(5);
  endfunction

  always @(posedge clk) begin
    m_err = 1'b0;
    if (rst) begin
      ph = P_IDLE; m_due = 0; m_jam = 1'b0; cur = 0; waited = 0; rel_left = 0;
      coins.delete();
    end else begin
      case (ph)
        P_IDLE: if (bus.vend_req) begin
          if (int'(bus.credit) >= PRICE) begin
            m_due = int'(bus.credit) - PRICE;
            plan(m_due);
            rel_left = REL;
            ph = P_REL;
          end else begin
            m_err = 1'b1;
          end
        end
        P_REL: begin
          rel_left--;
          if (rel_left == 0) ph = P_SEL;
        end
        P_SEL: begin
          if (coins.size() == 0) ph = P_DONE;
          else begin
            cur = coins.pop_front();
            waited = 0;
            ph = P_STB;
          end
        end
        P_STB: begin
          if (bus.hopper_ack) begin
            m_due -= cur;
            ph = P_SEL;
          end else begin
            waited++;
            if (waited == TMO) begin
              m_jam = 1'b1;
              ph = P_FAULT;
            end
          end
        end
        P_DONE: ph = P_IDLE;
        default: ph = P_FAULT;
      endcase
    end
  end

  // Per-cycle compare against the model, plus an observation log of the DUT.
  int rel_cnt = 0;
  int strobe_run = 0;
  int coin_log[$];
  int len_log[$];
  int due_log[$];
  logic [CW-1:0] prev_due = '0;

  always @(negedge clk) begin
    int s;
    chk("busy", bus.busy, ph != P_IDLE);
    chk("item_rel", bus.item_rel, ph == P_REL);
    chk("coin50", bus.coin50, (ph == P_STB) && (cur == 50));
    chk("coin10", bus.coin10, (ph == P_STB) && (cur == 10));
    chk("coin5", bus.coin5, (ph == P_STB) && (cur == 5));
    chk("done", bus.done, ph == P_DONE);
    chk("err", bus.err, m_err);
    chk("jam", bus.jam, m_jam);
    chk("change_due", bus.change_due, m_due);
    chk("one strobe", (32'(bus.coin50) + 32'(bus.coin10) + 32'(bus.coin5)) <= 1, 1);

    if (bus.item_rel) rel_cnt++;
    s = bus.coin50 ? 50 : bus.coin10 ? 10 : bus.coin5 ? 5 : 0;
    if (s != 0) begin
      if (strobe_run == 0) coin_log.push_back(s);
      strobe_run++;
    end else if (strobe_run > 0) begin
      len_log.push_back(strobe_run);
      strobe_run = 0;
    end
    if (bus.change_due !== prev_due) begin
      due_log.push_back(int'(bus.change_due));
      prev_due = bus.change_due;
    end
  end

  // Hopper: 0 never acks, 1 ack held high, 2 ack on the 7th strobe cycle.
  int ack_mode = 1;
  initial begin
    int run;
    run = 0;
    bus.hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.coin50 | bus.coin10 | bus.coin5) run++;
      else run = 0;
      case (ack_mode)
        0:       bus.hopper_ack = 1'b0;
        1:       bus.hopper_ack = 1'b1;
        default: bus.hopper_ack = (run == 7);
      endcase
    end
  end

  task automatic vend(input int c);
    bus.credit   = CW'(c);
    bus.vend_req = 1'b1;
    @(negedge clk);
    bus.vend_req = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int k);
    k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " done seen"}, bus.done, 1);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"}, bus.busy, 0);
    chk({nm, " item_rel"}, bus.item_rel, 0);
    chk({nm, " strobes"}, {bus.coin50, bus.coin10, bus.coin5}, 0);
    chk({nm, " change_due"}, bus.change_due, 0);
    chk({nm, " done"}, bus.done, 0);
    chk({nm, " err"}, bus.err, 0);
    chk({nm, " jam"}, bus.jam, 0);
  endtask

  initial begin
    int k, r0, c0, l0, d0;
    bus.vend_req = 1'b0;
    bus.credit   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Exact credit: no coins, done 5 negedges after the accept.
    r0 = rel_cnt; c0 = coin_log.size();
    vend(125);
    chk("exact busy at accept", bus.busy, 1);
    chk("exact item_rel at accept", bus.item_rel, 1);
    wait_done("exact", k);
    chk("exact done latency", k, 5);
    chk("exact busy after", bus.busy, 0);
    chk("exact item_rel cycles", rel_cnt - r0, 4);
    chk("exact coin count", coin_log.size() - c0, 0);
    chk("exact change_due", bus.change_due, 0);

    // 190: 65 -> 15 -> 5 -> 0 via 50, 10, 5.
    c0 = coin_log.size(); d0 = due_log.size(); l0 = len_log.size();
    vend(190);
    chk("model due 190", m_due, 65);
    wait_done("pay190", k);
    chk("pay190 coin count", coin_log.size() - c0, 3);
    chk("pay190 coin 1", coin_log[c0], 50);
    chk("pay190 coin 2", coin_log[c0+1], 10);
    chk("pay190 coin 3", coin_log[c0+2], 5);
    chk("pay190 due steps", due_log.size() - d0, 4);
    chk("pay190 due 1", due_log[d0], 65);
    chk("pay190 due 2", due_log[d0+1], 15);
    chk("pay190 due 3", due_log[d0+2], 5);
    chk("pay190 due 4", due_log[d0+3], 0);
    chk("pay190 strobe len", len_log[l0], 1);

    // 128: residue 3 stays visible.
    vend(128);
    wait_done("residue", k);
    chk("residue change_due", bus.change_due, 3);

    // Underpay leaves the residue untouched.
    vend(100);
    chk("underpay err", bus.err, 1);
    chk("underpay busy", bus.busy, 0);
    @(negedge clk);
    chk("underpay err cleared", bus.err, 0);
    chk("underpay item_rel", bus.item_rel, 0);
    chk("underpay change_due", bus.change_due, 3);

    c0 = coin_log.size();
    vend(225);
    wait_done("pay225", k);
    chk("pay225 coin count", coin_log.size() - c0, 2);
    chk("pay225 coin 1", coin_log[c0], 50);
    chk("pay225 coin 2", coin_log[c0+1], 50);
    chk("pay225 change_due", bus.change_due, 0);

    // Delayed ack, with a vend_req landing mid-payout.
    ack_mode = 2;
    c0 = coin_log.size(); l0 = len_log.size();
    vend(140);
    repeat (8) @(negedge clk);
    chk("midpay strobe high", bus.coin10, 1);
    vend(200);
    wait_done("pay140", k);
    chk("pay140 coin count", coin_log.size() - c0, 2);
    chk("pay140 coin 1", coin_log[c0], 10);
    chk("pay140 coin 2", coin_log[c0+1], 5);
    chk("pay140 len 1", len_log[l0], 7);
    chk("pay140 len 2", len_log[l0+1], 7);
    chk("pay140 busy after", bus.busy, 0);
    chk("pay140 change_due", bus.change_due, 0);

    // Ack high while idle.
    ack_mode = 1;
    repeat (3) @(negedge clk);
    chk_all_zero("idle ack");

    // Reset in the second RELEASE cycle.
    vend(130);
    @(negedge clk);
    chk("rst-rel in release", bus.item_rel, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst-rel");
    c0 = coin_log.size();
    vend(130);
    wait_done("after rst-rel", k);
    chk("after rst-rel coins", coin_log.size() - c0, 1);
    chk("after rst-rel coin", coin_log[c0], 5);
    chk("after rst-rel change", bus.change_due, 0);

    // Reset during WAIT_ACK.
    ack_mode = 0;
    vend(150);
    k = 0;
    while (!bus.coin10 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst-wait strobe seen", bus.coin10, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst-wait");
    ack_mode = 1;
    @(negedge clk);
    c0 = coin_log.size();
    vend(130);
    wait_done("after rst-wait", k);
    chk("after rst-wait coins", coin_log.size() - c0, 1);
    chk("after rst-wait coin", coin_log[c0], 5);

    // Jam: coin50 held TMO cycles, then sticky fault.
    ack_mode = 0;
    @(negedge clk);
    l0 = len_log.size(); c0 = coin_log.size();
    vend(175);
    k = 0;
    while (!bus.jam && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("jam seen", bus.jam, 1);
    @(negedge clk);
    chk("jam coin", coin_log[c0], 50);
    chk("jam strobe len", len_log[l0], 16);
    chk("jam busy", bus.busy, 1);
    chk("jam change_due", bus.change_due, 50);
    chk("jam strobes low", {bus.coin50, bus.coin10, bus.coin5}, 0);
    vend(200);
    repeat (3) @(negedge clk);
    chk("jam ignores vend busy", bus.busy, 1);
    chk("jam ignores vend due", bus.change_due, 50);
    chk("jam ignores vend err", bus.err, 0);
    chk("jam still set", bus.jam, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("jam reset");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
